wcb_store_buffer: RTL and testbench

Parametrised write-combining store buffer for the data-memory stage, successor to the single-word store buffer. Holds up to N_LINES cache-line-sized entries, each with a per-byte valid mask. Stores to an already-buffered line are merged into that entry. Loads get byte-granular forwarding with full/partial hit reporting, and entries drain oldest-first to the data cache through a valid/ready handshake, with an explicit flush mode.

---
 rtl/cache_pkg.sv | 42 ++++
 rtl/wcb_fwd_lookup.sv | 61 ++++++
 rtl/wcb_store_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_wcb_store_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared data-memory types: store-size encoding, write-combining entry layout and byte-mask helper.
// Entry geometry (address width, line size) is fixed here and followed by the buffer.
package cache_pkg;

    localparam int CACHE_VA_WIDTH   = 32;
    localparam int CACHE_LINE_BYTES = 16;
    localparam int CACHE_OFF        = $clog2(CACHE_LINE_BYTES);
    localparam int CACHE_TAG_W      = CACHE_VA_WIDTH - CACHE_OFF;

    // Same encoding as mem_control_t.size
    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } wcb_state_e;

    typedef struct packed {
        logic                          valid;
        logic                          locked;
        logic [CACHE_TAG_W-1:0]        tag;
        logic [CACHE_LINE_BYTES*8-1:0] data;
        logic [CACHE_LINE_BYTES-1:0]   mask;
    } wcb_entry_t;

    function automatic logic [CACHE_LINE_BYTES-1:0] size_to_bytemask(
        input logic [1:0]           size,
        input logic [CACHE_OFF-1:0] offset
    );
        logic [CACHE_LINE_BYTES-1:0] base;
        base = '0;
        for (int i = 0; i < 8; i++) begin
            base[i] = (i < (1 << size));
        end
        return base << offset;
    endfunction

endpackage

// File: rtl/wcb_fwd_lookup.sv
// Per-byte youngest-entry selection for store-to-load forwarding.
// Purely combinational, zero latency; no backpressure.
module wcb_fwd_lookup
    import cache_pkg::*;
#(
    parameter int N_LINES    = 4,
    parameter int VA_WIDTH   = CACHE_VA_WIDTH,
    parameter int REG_WIDTH  = 32,
    parameter int LINE_BYTES = CACHE_LINE_BYTES
) (
    input  logic [N_LINES-1:0]                            line_valid,
    input  logic [N_LINES-1:0][VA_WIDTH-$clog2(LINE_BYTES)-1:0] line_tag,
    input  logic [N_LINES-1:0][LINE_BYTES*8-1:0]          line_data,
    input  logic [N_LINES-1:0][LINE_BYTES-1:0]            line_mask,
    input  logic [$clog2(N_LINES)-1:0]                    head,
    input  logic                                          load_valid,
    input  logic [VA_WIDTH-1:0]                           load_addr,
    input  logic [1:0]                                    load_size,
    output logic                                          hit,
    output logic                                          partial,
    output logic [REG_WIDTH-1:0]                          fwd_data
);

    localparam int OFF       = $clog2(LINE_BYTES);
    localparam int TAG_W     = VA_WIDTH - OFF;
    localparam int PTR_W     = $clog2(N_LINES);
    localparam int REG_BYTES = REG_WIDTH / 8;

    logic [TAG_W-1:0]     ld_tag;
    logic [OFF-1:0]       ld_off;
    logic [REG_BYTES-1:0] need;
    logic [REG_BYTES-1:0] found;
    logic [PTR_W-1:0]     idx;
    logic [OFF-1:0]       boff;

    assign ld_tag = load_addr[VA_WIDTH-1:OFF];
    assign ld_off = load_addr[OFF-1:0];

    // Walk oldest to youngest from head so later matches override earlier ones.
    always_comb begin
        need     = '0;
        found    = '0;
        fwd_data = '0;
        idx      = '0;
        boff     = '0;
        for (int b = 0; b < REG_BYTES; b++) begin
            need[b] = load_valid && (b < (1 << load_size));
            boff    = ld_off + OFF'(b);
            for (int k = 0; k < N_LINES; k++) begin
                idx = head + PTR_W'(k);
                if (line_valid[idx] && (line_tag[idx] == ld_tag) && line_mask[idx][boff]) begin
                    found[b]          = need[b];
                    fwd_data[b*8 +: 8] = need[b] ? line_data[idx][{boff, 3'b000} +: 8] : 8'h00;
                end
            end
        end
        hit     = (need != '0) && (found == need);
        partial = (found != '0) && (found != need);
    end

endmodule

// File: rtl/wcb_store_buffer.sv
// Write-combining store buffer: merges stores per line, forwards bytes to loads, drains oldest-first.
// Stores land one cycle after acceptance; drain holds the head stable until i_drain_ready, stores blocked in FLUSH.
module wcb_store_buffer
    import cache_pkg::*;
#(
    parameter int N_LINES         = 4,
    parameter int VA_WIDTH        = CACHE_VA_WIDTH,
    parameter int REG_WIDTH       = 32,
    parameter int LINE_BYTES      = CACHE_LINE_BYTES,
    parameter int DRAIN_THRESHOLD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_store_valid,
    input  logic [VA_WIDTH-1:0]     i_store_addr,
    input  logic [1:0]              i_store_size,
    input  logic [REG_WIDTH-1:0]    i_store_data,
    output logic                    o_store_ready,
    input  logic                    i_load_valid,
    input  logic [VA_WIDTH-1:0]     i_load_addr,
    input  logic [1:0]              i_load_size,
    output logic                    o_fwd_hit,
    output logic                    o_fwd_partial,
    output logic [REG_WIDTH-1:0]    o_fwd_data,
    output logic                    o_drain_valid,
    output logic [VA_WIDTH-1:0]     o_drain_addr,
    output logic [LINE_BYTES*8-1:0] o_drain_data,
    output logic [LINE_BYTES-1:0]   o_drain_mask,
    input  logic                    i_drain_ready,
    input  logic                    i_flush,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int TAG_W  = VA_WIDTH - OFF;
    localparam int PTR_W  = $clog2(N_LINES);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(DRAIN_THRESHOLD);
    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(N_LINES);

    wcb_entry_t [N_LINES-1:0] entries;
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_nxt;
    wcb_state_e               state;
    wcb_state_e               state_nxt;

    logic [TAG_W-1:0]      st_tag;
    logic [OFF-1:0]        st_off;
    logic [2:0]            st_align;
    logic                  st_legal;
    logic [LINE_BYTES-1:0] st_mask;
    logic [LINE_W-1:0]     st_wide;
    logic [LINE_W-1:0]     st_shift;
    logic [LINE_W-1:0]     st_line;
    logic                  match_any;
    logic [PTR_W-1:0]      match_idx;
    logic                  store_fire;
    logic                  do_merge;
    logic                  do_alloc;
    logic                  pop;

    always_comb begin
        st_tag = i_store_addr[VA_WIDTH-1:OFF];
        st_off = i_store_addr[OFF-1:0];
        case (i_store_size)
            SIZE_BYTE:  st_align = 3'b000;
            SIZE_HALF:  st_align = 3'b001;
            SIZE_WORD:  st_align = 3'b011;
            SIZE_DWORD: st_align = 3'b111;
            default:    st_align = 3'b111;
        endcase
        st_legal = ((i_store_addr[2:0] & st_align) == 3'b000) &&
                   ((32'd8 << i_store_size) <= REG_WIDTH);
        st_mask  = size_to_bytemask(i_store_size, st_off);
        st_wide  = '0;
        st_wide[REG_WIDTH-1:0] = i_store_data;
        st_shift = st_wide << {st_off, 3'b000};
        for (int b = 0; b < LINE_BYTES; b++) begin
            st_line[b*8 +: 8] = st_mask[b] ? st_shift[b*8 +: 8] : 8'h00;
        end
    end

    assign o_empty       = (count == '0);
    assign o_full        = (count == CAPACITY);
    assign o_drain_valid = ((state == DRAIN) || (state == FLUSH)) && !o_empty;
    assign o_drain_addr  = {entries[head].tag, {OFF{1'b0}}};
    assign o_drain_data  = entries[head].data;
    assign o_drain_mask  = entries[head].mask;

    // The head being offered this cycle counts as locked even before its lock bit lands.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (entries[i].valid && !entries[i].locked &&
                !(o_drain_valid && (PTR_W'(i) == head)) &&
                (entries[i].tag == st_tag)) begin
                match_any = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
    end

    assign o_store_ready = (state != FLUSH) && (match_any || !o_full);
    assign store_fire    = i_store_valid && o_store_ready && st_legal;
    assign do_merge      = store_fire && match_any;
    assign do_alloc      = store_fire && !match_any;
    assign pop           = o_drain_valid && i_drain_ready;
    assign count_nxt     = count + CNT_W'(do_alloc) - CNT_W'(pop);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_flush)              state_nxt = FLUSH;
                else if (count >= THRESH) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (i_flush)                 state_nxt = FLUSH;
                else if (count_nxt < THRESH) state_nxt = IDLE;
            end
            FLUSH: begin
                if (o_empty) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            state   <= IDLE;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (o_drain_valid) begin
                entries[head].locked <= 1'b1;
            end
            if (pop) begin
                entries[head].valid  <= 1'b0;
                entries[head].locked <= 1'b0;
                head                 <= head + 1'b1;
            end
            if (do_merge) begin
                for (int b = 0; b < LINE_BYTES; b++) begin
                    if (st_mask[b]) begin
                        entries[match_idx].data[b*8 +: 8] <= st_line[b*8 +: 8];
                    end
                end
                entries[match_idx].mask <= entries[match_idx].mask | st_mask;
            end
            if (do_alloc) begin
                entries[tail] <= '{valid: 1'b1, locked: 1'b0, tag: st_tag,
                                   data: st_line, mask: st_mask};
                tail          <= tail + 1'b1;
            end
        end
    end

    logic [N_LINES-1:0]              ent_valid;
    logic [N_LINES-1:0][TAG_W-1:0]   ent_tag;
    logic [N_LINES-1:0][LINE_W-1:0]  ent_data;
    logic [N_LINES-1:0][LINE_BYTES-1:0] ent_mask;

    always_comb begin
        for (int i = 0; i < N_LINES; i++) begin
            ent_valid[i] = entries[i].valid;
            ent_tag[i]   = entries[i].tag;
            ent_data[i]  = entries[i].data;
            ent_mask[i]  = entries[i].mask;
        end
    end

    wcb_fwd_lookup #(
        .N_LINES    (N_LINES),
        .VA_WIDTH   (VA_WIDTH),
        .REG_WIDTH  (REG_WIDTH),
        .LINE_BYTES (LINE_BYTES)
    ) u_fwd (
        .line_valid (ent_valid),
        .line_tag   (ent_tag),
        .line_data  (ent_data),
        .line_mask  (ent_mask),
        .head       (head),
        .load_valid (i_load_valid),
        .load_addr  (i_load_addr),
        .load_size  (i_load_size),
        .hit        (o_fwd_hit),
        .partial    (o_fwd_partial),
        .fwd_data   (o_fwd_data)
    );

endmodule

// File: tb/tb_wcb_store_buffer.sv
// Bench for wcb_store_buffer: vector table for merge/forward behaviour, hand sequences for drain/flush/reset.
module tb_wcb_store_buffer;

    logic         clk;
    logic         rst;
    logic         i_store_valid;
    logic [31:0]  i_store_addr;
    logic [1:0]   i_store_size;
    logic [31:0]  i_store_data;
    logic         o_store_ready;
    logic         i_load_valid;
    logic [31:0]  i_load_addr;
    logic [1:0]   i_load_size;
    logic         o_fwd_hit;
    logic         o_fwd_partial;
    logic [31:0]  o_fwd_data;
    logic         o_drain_valid;
    logic [31:0]  o_drain_addr;
    logic [127:0] o_drain_data;
    logic [15:0]  o_drain_mask;
    logic         i_drain_ready;
    logic         i_flush;
    logic         o_full;
    logic         o_empty;

    wcb_store_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .i_store_valid (i_store_valid),
        .i_store_addr  (i_store_addr),
        .i_store_size  (i_store_size),
        .i_store_data  (i_store_data),
        .o_store_ready (o_store_ready),
        .i_load_valid  (i_load_valid),
        .i_load_addr   (i_load_addr),
        .i_load_size   (i_load_size),
        .o_fwd_hit     (o_fwd_hit),
        .o_fwd_partial (o_fwd_partial),
        .o_fwd_data    (o_fwd_data),
        .o_drain_valid (o_drain_valid),
        .o_drain_addr  (o_drain_addr),
        .o_drain_data  (o_drain_data),
        .o_drain_mask  (o_drain_mask),
        .i_drain_ready (i_drain_ready),
        .i_flush       (i_flush),
        .o_full        (o_full),
        .o_empty       (o_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0]  a;
        logic [127:0] d;
        logic [15:0]  m;
    } drain_t;

    drain_t exp_q[$];

    // Scoreboard: every accepted drain is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst && o_drain_valid && i_drain_ready) begin
            if (exp_q.size() == 0) begin
                check("drain_unexpected", 128'(o_drain_addr), 128'hFFFF_FFFF);
            end else begin
                drain_t e;
                e = exp_q.pop_front();
                check("drain_addr", 128'(o_drain_addr), 128'(e.a));
                check("drain_data", o_drain_data, e.d);
                check("drain_mask", 128'(o_drain_mask), 128'(e.m));
            end
        end
    end

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [1:0]  ss;
        logic [31:0] sd;
        logic [31:0] la;
        logic [1:0]  ls;
        logic        hit;
        logic        part;
        logic [31:0] fd;
        logic        empty;
        logic        full;
        logic        srdy;
        logic        dvld;
    } vec_t;

    vec_t vecs[13];

    task automatic set_store(input logic v, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        i_store_valid = v;
        i_store_addr  = a;
        i_store_size  = s;
        i_store_data  = d;
    endtask

    initial begin
        int nd;
        vecs[0]  = '{1'b0, 32'h0,    2'd0, 32'h0,        32'h1003, 2'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h1003, 2'd0, 32'hAB,       32'h1003, 2'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,    2'd0, 32'h0,        32'h1003, 2'd0, 1'b1, 1'b0, 32'hAB,       1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h1000, 2'd2, 32'h11223344, 32'h1003, 2'd0, 1'b1, 1'b0, 32'hAB,       1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h1002, 2'd1, 32'hBEEF,     32'h1000, 2'd2, 1'b1, 1'b0, 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,    2'd0, 32'h0,        32'h1000, 2'd2, 1'b1, 1'b0, 32'hBEEF3344, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'hA001, 2'd1, 32'h1234,     32'h1003, 2'd0, 1'b1, 1'b0, 32'hBE,       1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,    2'd0, 32'h0,        32'hA000, 2'd1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 32'h2000, 2'd0, 32'h5A,       32'h2000, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,    2'd0, 32'h0,        32'h2000, 2'd2, 1'b0, 1'b1, 32'h5A,       1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'h1004, 2'd2, 32'hCAFEF00D, 32'h1004, 2'd2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 32'h0,    2'd0, 32'h0,        32'h1004, 2'd2, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 32'h0,    2'd0, 32'h0,        32'h1000, 2'd2, 1'b1, 1'b0, 32'hBEEF3344, 1'b0, 1'b0, 1'b1, 1'b1};

        rst           = 1'b0;
        set_store(1'b0, 32'h0, 2'd0, 32'h0);
        i_load_valid  = 1'b1;
        i_load_addr   = 32'h0;
        i_load_size   = 2'd0;
        i_drain_ready = 1'b0;
        i_flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;

        // Merge and forwarding vectors
        for (int i = 0; i < 13; i++) begin
            set_store(vecs[i].sv, vecs[i].sa, vecs[i].ss, vecs[i].sd);
            i_load_addr = vecs[i].la;
            i_load_size = vecs[i].ls;
            #1;
            check($sformatf("row%0d_hit", i),   128'(o_fwd_hit),     128'(vecs[i].hit));
            check($sformatf("row%0d_part", i),  128'(o_fwd_partial), 128'(vecs[i].part));
            check($sformatf("row%0d_data", i),  128'(o_fwd_data),    128'(vecs[i].fd));
            check($sformatf("row%0d_empty", i), 128'(o_empty),       128'(vecs[i].empty));
            check($sformatf("row%0d_full", i),  128'(o_full),        128'(vecs[i].full));
            check($sformatf("row%0d_srdy", i),  128'(o_store_ready), 128'(vecs[i].srdy));
            check($sformatf("row%0d_dvld", i),  128'(o_drain_valid), 128'(vecs[i].dvld));
            tick();
        end
        set_store(1'b0, 32'h0, 2'd0, 32'h0);
        #1;

        // Head held stable while the cache stalls
        check("hold_mask", 128'(o_drain_mask), 128'h000F);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_vld", i),  128'(o_drain_valid), 128'h1);
            check($sformatf("hold%0d_addr", i), 128'(o_drain_addr),  128'h1000);
            tick();
        end
        exp_q.push_back('{32'h1000, 128'h0000_0000_0000_0000_0000_0000_BEEF_3344, 16'h000F});
        i_drain_ready = 1'b1;
        tick();
        i_drain_ready = 1'b0;
        #1;
        check("pop1_vld",  128'(o_drain_valid), 128'h1);
        check("pop1_addr", 128'(o_drain_addr),  128'h2000);

        // Fill to capacity, coalesce while full, pop+push in one cycle
        set_store(1'b1, 32'h3000, 2'd0, 32'h33);
        #1;
        check("fill3_srdy", 128'(o_store_ready), 128'h1);
        tick();
        set_store(1'b1, 32'h4000, 2'd0, 32'h44);
        #1;
        check("fill4_srdy", 128'(o_store_ready), 128'h1);
        tick();
        set_store(1'b0, 32'h0, 2'd0, 32'h0);
        #1;
        check("full_flag", 128'(o_full), 128'h1);
        set_store(1'b1, 32'h5000, 2'd0, 32'h55);
        #1;
        check("full_newtag_srdy", 128'(o_store_ready), 128'h0);
        set_store(1'b1, 32'h3001, 2'd0, 32'h77);
        #1;
        check("full_merge_srdy", 128'(o_store_ready), 128'h1);
        tick();
        exp_q.push_back('{32'h2000, 128'h5A, 16'h0001});
        set_store(1'b1, 32'h5000, 2'd0, 32'h55);
        i_drain_ready = 1'b1;
        #1;
        check("poppush_srdy", 128'(o_store_ready), 128'h0);
        tick();
        set_store(1'b0, 32'h0, 2'd0, 32'h0);
        i_drain_ready = 1'b0;
        i_load_addr   = 32'h5000;
        i_load_size   = 2'd0;
        #1;
        check("poppush_full", 128'(o_full),        128'h0);
        check("poppush_miss", 128'(o_fwd_hit),     128'h0);
        check("poppush_head", 128'(o_drain_addr),  128'h1000);

        // Flush pulse drains the remaining three lines in order
        exp_q.push_back('{32'h1000, 128'h0000_0000_0000_0000_CAFE_F00D_0000_0000, 16'h00F0});
        exp_q.push_back('{32'h3000, 128'h7733, 16'h0003});
        exp_q.push_back('{32'h4000, 128'h44, 16'h0001});
        i_flush = 1'b1;
        tick();
        i_flush       = 1'b0;
        i_drain_ready = 1'b1;
        set_store(1'b1, 32'h6000, 2'd0, 32'h66);
        #1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_empty) break;
            check($sformatf("flush%0d_srdy", i), 128'(o_store_ready), 128'h0);
            if (o_drain_valid) nd++;
            tick();
        end
        check("flush_drains", 128'(nd), 128'd3);
        check("flush_empty",  128'(o_empty), 128'h1);
        check("flush_last_srdy", 128'(o_store_ready), 128'h0);
        set_store(1'b0, 32'h0, 2'd0, 32'h0);
        i_load_addr = 32'h6000;
        tick();
        check("idle_srdy",  128'(o_store_ready), 128'h1);
        check("idle_dvld",  128'(o_drain_valid), 128'h0);
        check("idle_miss",  128'(o_fwd_hit),     128'h0);

        // Reset in the middle of a flush
        i_drain_ready = 1'b0;
        set_store(1'b1, 32'h7000, 2'd0, 32'h71);
        tick();
        set_store(1'b1, 32'h8000, 2'd0, 32'h81);
        tick();
        set_store(1'b1, 32'h9000, 2'd0, 32'h91);
        tick();
        set_store(1'b0, 32'h0, 2'd0, 32'h0);
        i_flush     = 1'b1;
        i_load_addr = 32'h7000;
        tick();
        i_flush = 1'b0;
        #1;
        check("rflush_dvld", 128'(o_drain_valid), 128'h1);
        check("rflush_hit",  128'(o_fwd_hit),     128'h1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_dvld",  128'(o_drain_valid), 128'h0);
        check("rst_empty", 128'(o_empty),       128'h1);
        check("rst_full",  128'(o_full),        128'h0);
        check("rst_srdy",  128'(o_store_ready), 128'h1);
        check("rst_hit",   128'(o_fwd_hit),     128'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("post_rst_dvld",  128'(o_drain_valid), 128'h0);
        check("post_rst_empty", 128'(o_empty),       128'h1);

        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
